// File: rtl/line_ctrl_pkg.sv
// Shared types and helpers for the line-buffer sequencer.
package line_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_SHIFT,
        ST_PROCESS,
        ST_DONE
    } ctrl_state_t;

    localparam int MEM_READ_LATENCY = 1;

    function automatic int words_per_row(input int size_row);
        return size_row / 4;
    endfunction

endpackage

// File: rtl/row_word_counter.sv
// Word-column counter shared by row loads and result writes, plus the
// one-cycle delayed index/valid that follows each memory read into line c.
module row_word_counter #(
    parameter int WORDS = 88,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic             read_issued,
    input  logic             direct_next,
    output logic             last,
    output logic             buffer_write,
    output logic [IDX_W-1:0] write_index
);

    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(WORDS - 1);

    logic [IDX_W-1:0] k_q, k_d;
    logic             buffer_write_q, buffer_write_d;
    logic [IDX_W-1:0] write_index_q, write_index_d;

    assign last = (k_q == LAST_K);

    always_comb begin
        k_d = k_q;
        if (clear) begin
            k_d = '0;
        end else if (advance) begin
            k_d = last ? '0 : k_q + IDX_W'(1);
        end

        // Reads land one cycle later, so the load index trails k by a cycle;
        // result writes present the window select alongside the address.
        buffer_write_d = read_issued;
        write_index_d  = '0;
        if (direct_next) begin
            write_index_d = k_d;
        end else if (read_issued) begin
            write_index_d = k_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q            <= '0;
            buffer_write_q <= 1'b0;
            write_index_q  <= '0;
        end else begin
            k_q            <= k_d;
            buffer_write_q <= buffer_write_d;
            write_index_q  <= write_index_d;
        end
    end

    assign buffer_write = buffer_write_q;
    assign write_index  = write_index_q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Frame sequencer: loads rows into the three-line buffer, shifts lines and
// writes one filtered result row per buffered row triple.
module line_buffer_ctrl
    import line_ctrl_pkg::*;
#(
    parameter int SIZE_ROW    = 352,
    parameter int SIZE_COL    = 288,
    parameter int ADDR_W      = 16,
    parameter int RESULT_BASE = (SIZE_ROW / 4) * SIZE_COL
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          finish,
    output logic                          en,
    output logic                          we,
    output logic [ADDR_W-1:0]             addr,
    output logic                          buffer_write,
    output logic [$clog2(SIZE_ROW/4)-1:0] write_index,
    output logic                          buffer_shift
);

    localparam int W     = words_per_row(SIZE_ROW);
    localparam int IDX_W = $clog2(SIZE_ROW / 4);
    localparam int ROW_W = $clog2(SIZE_COL);

    localparam logic [ADDR_W-1:0] W_A        = ADDR_W'(W);
    localparam logic [ADDR_W-1:0] RES_BASE_A = ADDR_W'(RESULT_BASE);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(SIZE_COL - 1);

    if (SIZE_ROW % 4 != 0 || W < 2) begin : g_bad_row
        $error("line_buffer_ctrl: SIZE_ROW must be a multiple of 4 and at least 8");
    end
    if (SIZE_COL < 3) begin : g_bad_col
        $error("line_buffer_ctrl: SIZE_COL must be at least 3");
    end
    if (longint'(RESULT_BASE) + longint'(W) * longint'(SIZE_COL) - 1 >= (longint'(1) << ADDR_W)) begin : g_bad_addr
        $error("line_buffer_ctrl: result image exceeds ADDR_W address space");
    end
    if (MEM_READ_LATENCY != 1) begin : g_bad_lat
        $error("line_buffer_ctrl: delayed write path assumes one-cycle read latency");
    end

    ctrl_state_t       state_q, state_d;
    logic [ROW_W-1:0]  load_row_q, load_row_d;
    logic [ADDR_W-1:0] load_base_q, load_base_d;
    logic              en_q, en_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              buffer_shift_q, buffer_shift_d;
    logic              finish_q, finish_d;

    logic              cnt_clear, cnt_advance, cnt_last;
    logic [ADDR_W-1:0] proc_base;

    // Once load_row rows are buffered, the middle line is load_row-1.
    assign proc_base = RES_BASE_A + load_base_q - W_A;

    always_comb begin
        state_d        = state_q;
        load_row_d     = load_row_q;
        load_base_d    = load_base_q;
        en_d           = 1'b0;
        we_d           = 1'b0;
        addr_d         = '0;
        buffer_shift_d = 1'b0;
        finish_d       = 1'b0;
        cnt_clear      = 1'b0;
        cnt_advance    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    load_row_d  = '0;
                    load_base_d = '0;
                    en_d        = 1'b1;
                    cnt_clear   = 1'b1;
                end
            end
            ST_LOAD: begin
                cnt_advance = 1'b1;
                if (cnt_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    en_d   = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                cnt_clear = 1'b1;
                if (load_row_q < ROW_W'(2)) begin
                    state_d        = ST_SHIFT;
                    buffer_shift_d = 1'b1;
                end else begin
                    state_d = ST_PROCESS;
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = proc_base;
                end
            end
            ST_SHIFT: begin
                cnt_clear   = 1'b1;
                state_d     = ST_LOAD;
                load_row_d  = load_row_q + ROW_W'(1);
                load_base_d = load_base_q + W_A;
                en_d        = 1'b1;
                addr_d      = load_base_q + W_A;
            end
            ST_PROCESS: begin
                cnt_advance = 1'b1;
                if (cnt_last) begin
                    if (load_row_q < LAST_ROW) begin
                        state_d        = ST_SHIFT;
                        buffer_shift_d = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                        finish_d = 1'b1;
                    end
                end else begin
                    en_d   = 1'b1;
                    we_d   = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            load_row_q     <= '0;
            load_base_q    <= '0;
            en_q           <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            buffer_shift_q <= 1'b0;
            finish_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_row_q     <= load_row_d;
            load_base_q    <= load_base_d;
            en_q           <= en_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            buffer_shift_q <= buffer_shift_d;
            finish_q       <= finish_d;
        end
    end

    row_word_counter #(
        .WORDS (W),
        .IDX_W (IDX_W)
    ) u_counter (
        .clk          (clk),
        .reset        (reset),
        .clear        (cnt_clear),
        .advance      (cnt_advance),
        .read_issued  (state_q == ST_LOAD),
        .direct_next  (state_d == ST_PROCESS),
        .last         (cnt_last),
        .buffer_write (buffer_write),
        .write_index  (write_index)
    );

    assign en           = en_q;
    assign we           = we_q;
    assign addr         = addr_q;
    assign buffer_shift = buffer_shift_q;
    assign finish       = finish_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench: cycle-exact small frame (8x4) plus a full default frame sweep.
module tb_line_buffer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance: SIZE_ROW=8, SIZE_COL=4 -> W=2, RESULT_BASE=8
    logic        rst_s, start_s, fin_s, en_s, we_s, bw_s, bs_s;
    logic [15:0] addr_s;
    logic [0:0]  wi_s;

    // Default instance: 352x288
    logic        rst_l, start_l, fin_l, en_l, we_l, bw_l, bs_l;
    logic [15:0] addr_l;
    logic [6:0]  wi_l;

    line_buffer_ctrl #(.SIZE_ROW(8), .SIZE_COL(4)) dut_small (
        .clk          (clk),
        .reset        (rst_s),
        .start        (start_s),
        .finish       (fin_s),
        .en           (en_s),
        .we           (we_s),
        .addr         (addr_s),
        .buffer_write (bw_s),
        .write_index  (wi_s),
        .buffer_shift (bs_s)
    );

    line_buffer_ctrl dut_large (
        .clk          (clk),
        .reset        (rst_l),
        .start        (start_l),
        .finish       (fin_l),
        .en           (en_l),
        .we           (we_l),
        .addr         (addr_l),
        .buffer_write (bw_l),
        .write_index  (wi_l),
        .buffer_shift (bs_l)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("ok   %s = 0x%0h", tag, got);
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {en, we, addr[15:0], buffer_write, write_index, buffer_shift, finish}
    function automatic logic [31:0] pk(input bit e, input bit w, input int a,
                                       input bit b, input int wi, input bit s, input bit f);
        logic [15:0] a16;
        logic        wi1;
        a16 = a[15:0];
        wi1 = wi[0];
        return {10'b0, e, w, a16, b, wi1, s, f};
    endfunction

    function automatic logic [31:0] small_obs();
        return pk(en_s, we_s, int'(addr_s), bw_s, int'(wi_s), bs_s, fin_s);
    endfunction

    logic [31:0] exp_seq [1:21];

    task automatic init_table();
        exp_seq[1]  = pk(1, 0, 0,  0, 0, 0, 0);  // LOAD row 0
        exp_seq[2]  = pk(1, 0, 1,  1, 0, 0, 0);
        exp_seq[3]  = pk(0, 0, 0,  1, 1, 0, 0);  // DRAIN
        exp_seq[4]  = pk(0, 0, 0,  0, 0, 1, 0);  // SHIFT
        exp_seq[5]  = pk(1, 0, 2,  0, 0, 0, 0);  // LOAD row 1
        exp_seq[6]  = pk(1, 0, 3,  1, 0, 0, 0);
        exp_seq[7]  = pk(0, 0, 0,  1, 1, 0, 0);
        exp_seq[8]  = pk(0, 0, 0,  0, 0, 1, 0);
        exp_seq[9]  = pk(1, 0, 4,  0, 0, 0, 0);  // LOAD row 2
        exp_seq[10] = pk(1, 0, 5,  1, 0, 0, 0);
        exp_seq[11] = pk(0, 0, 0,  1, 1, 0, 0);
        exp_seq[12] = pk(1, 1, 10, 0, 0, 0, 0);  // PROCESS result row 1
        exp_seq[13] = pk(1, 1, 11, 0, 1, 0, 0);
        exp_seq[14] = pk(0, 0, 0,  0, 0, 1, 0);
        exp_seq[15] = pk(1, 0, 6,  0, 0, 0, 0);  // LOAD row 3
        exp_seq[16] = pk(1, 0, 7,  1, 0, 0, 0);
        exp_seq[17] = pk(0, 0, 0,  1, 1, 0, 0);
        exp_seq[18] = pk(1, 1, 12, 0, 0, 0, 0);  // PROCESS result row 2
        exp_seq[19] = pk(1, 1, 13, 0, 1, 0, 0);
        exp_seq[20] = pk(0, 0, 0,  0, 0, 0, 1);  // DONE
        exp_seq[21] = pk(0, 0, 0,  0, 0, 0, 0);  // IDLE
    endtask

    // Called at a negedge with the small DUT idle; start pulses inside the
    // frame are placed on the given cycle numbers (0 = none).
    task automatic run_small(input string name, input int pulse_a, input int pulse_b);
        int shifts;
        int fins;
        shifts  = 0;
        fins    = 0;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            check_val($sformatf("%s_c%0d", name, c), small_obs(), exp_seq[c]);
            if (bs_s) shifts++;
            if (fin_s) fins++;
            start_s = (c == pulse_a || c == pulse_b);
            @(negedge clk);
        end
        start_s = 1'b0;
        for (int c = 22; c <= 23; c++) begin
            check_val($sformatf("%s_idle%0d", name, c), small_obs(), 32'd0);
            @(negedge clk);
        end
        check_val($sformatf("%s_shifts", name), 32'(shifts), 32'd3);
        check_val($sformatf("%s_finish", name), 32'(fins), 32'd1);
    endtask

    initial begin
        int writes, bad_range, bad_order, clash, done, last_addr, exp_addr;

        init_table();
        rst_s   = 1'b1;
        start_s = 1'b1;     // must not be taken while reset is high
        rst_l   = 1'b1;
        start_l = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_hold", small_obs(), 32'd0);
        rst_s   = 1'b0;
        rst_l   = 1'b0;
        start_s = 1'b0;
        @(negedge clk);
        check_val("reset_release", small_obs(), 32'd0);
        check_val("reset_large", {en_l, we_l, addr_l, bw_l, wi_l, bs_l, fin_l}, 32'd0);

        run_small("frame", 0, 0);
        run_small("ignored", 12, 20);
        run_small("replay", 0, 0);

        // Reset during the second row load, while addr=3 is on the bus
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (5) @(negedge clk);
        check_val("mid_pre", small_obs(), exp_seq[6]);
        rst_s = 1'b1;
        @(negedge clk);
        check_val("mid_reset", small_obs(), 32'd0);
        rst_s = 1'b0;
        @(negedge clk);
        check_val("mid_idle", small_obs(), 32'd0);
        run_small("after_reset", 0, 0);

        // Full default frame
        writes    = 0;
        bad_range = 0;
        bad_order = 0;
        clash     = 0;
        done      = 0;
        last_addr = 0;
        exp_addr  = 25432;
        start_l   = 1'b1;
        @(negedge clk);
        start_l = 1'b0;
        for (int i = 0; i < 60000 && done == 0; i++) begin
            if (we_l) begin
                writes++;
                if (int'(addr_l) != exp_addr) bad_order++;
                if (int'(addr_l) < 25432 || int'(addr_l) > 50599) bad_range++;
                exp_addr++;
                last_addr = int'(addr_l);
            end
            if ((bw_l && we_l) || (bs_l && en_l)) clash++;
            if (fin_l) done = 1;
            @(negedge clk);
        end
        check_val("large_done", 32'(done), 32'd1);
        check_val("large_writes", 32'(writes), 32'd25168);
        check_val("large_range", 32'(bad_range), 32'd0);
        check_val("large_order", 32'(bad_order), 32'd0);
        check_val("large_last", 32'(last_addr), 32'd50599);
        check_val("large_clash", 32'(clash), 32'd0);
        check_val("large_idle", {en_l, we_l, addr_l, bw_l, wi_l, bs_l, fin_l}, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
